// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MDU tracker state
// encoding, the hard-wired zero register index and the default MDU latency.
package hazard_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MDU_LAT_DEF = 4;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_mdu_busy_tracker.sv
// Tracks an in-flight mult/div. A start pulse moves the tracker to BUSY for
// exactly MDU_LAT cycles. The busy output is the registered FSM state, so it
// also serves as the state observation point.
module mdu_busy_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // Next-state and counter logic: load MDU_LAT-1 on issue, count down to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == BUSY);

endmodule : mdu_busy_tracker

// File: rtl/hazard_ctrl.sv
// Stall/flush controller on the ID side of the 5-stage pipeline. Detects
// load-use and HI/LO-while-MDU-busy hazards, freezes PC and IF/ID, injects a
// bubble into ID/EX, and flushes IF/ID and ID/EX on a taken branch in EX.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int CNT_W   = 3,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic              ID_use_rs,
    input  logic              ID_use_rt,
    input  logic              ID_mdu_start,
    input  logic              ID_hilo_read,
    input  logic              EX_MemRead,
    input  logic [4:0]        EX_WR_out,
    input  logic              EX_branch_taken,
    output logic              PC_write,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic              ID_EX_flush,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    logic              load_use;
    logic              mdu_hz;
    logic              stall;
    logic              mdu_issue;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    // Hazard decode. A load into $0 never creates a dependency, and a taken
    // branch squashes the ID instruction so its hazard is irrelevant.
    always_comb begin
        load_use = EX_MemRead && (EX_WR_out != REG_ZERO) &&
                   ((ID_use_rs && (ID_Rs == EX_WR_out)) ||
                    (ID_use_rt && (ID_Rt == EX_WR_out)));
        mdu_hz   = mdu_busy && (ID_hilo_read || ID_mdu_start);
        stall    = (load_use || mdu_hz) && !EX_branch_taken;
        // Only a mult/div that actually leaves ID starts the MDU.
        mdu_issue = ID_mdu_start && !stall && !EX_branch_taken;
    end

    // Pipeline control outputs; the branch flush wins over any stall.
    always_comb begin
        PC_write    = !stall;
        IF_ID_write = !stall;
        IF_ID_flush = EX_branch_taken;
        ID_EX_flush = stall || EX_branch_taken;
    end

    mdu_busy_tracker #(
        .MDU_LAT (MDU_LAT),
        .CNT_W   (CNT_W)
    ) u_mdu_busy_tracker (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_issue),
        .busy  (mdu_busy)
    );

    // Saturating stall-cycle counter; flush-only cycles are not stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all
// checked against a cycle-indexed reference model of the hazard rules.
module tb_hazard_ctrl;

    localparam int MDU_LAT = 4;
    localparam int PERF_W  = 16;
    localparam int SAT_W   = 3;

    logic              clk;
    logic              rst;
    logic [4:0]        ID_Rs, ID_Rt, EX_WR_out;
    logic              ID_use_rs, ID_use_rt, ID_mdu_start, ID_hilo_read;
    logic              EX_MemRead, EX_branch_taken;
    logic              PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, mdu_busy;
    logic [PERF_W-1:0] stall_cnt;
    logic              s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_mdu_busy;
    logic [SAT_W-1:0]  s_stall_cnt;

    int n_total;
    int n_pass;

    // Reference model state: cycle index and the cycle of the last MDU issue.
    int cyc;
    int issue_cyc;
    int exp_cnt;

    hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(3), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .ID_mdu_start(ID_mdu_start), .ID_hilo_read(ID_hilo_read),
        .EX_MemRead(EX_MemRead), .EX_WR_out(EX_WR_out),
        .EX_branch_taken(EX_branch_taken),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    // Narrow perf counter instance so saturation is reachable in a short run.
    hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(3), .PERF_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .ID_mdu_start(ID_mdu_start), .ID_hilo_read(ID_hilo_read),
        .EX_MemRead(EX_MemRead), .EX_WR_out(EX_WR_out),
        .EX_branch_taken(EX_branch_taken),
        .PC_write(s_pc_write), .IF_ID_write(s_if_id_write),
        .IF_ID_flush(s_if_id_flush), .ID_EX_flush(s_id_ex_flush),
        .mdu_busy(s_mdu_busy), .stall_cnt(s_stall_cnt)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic bit model_busy();
        return (cyc > issue_cyc) && (cyc <= issue_cyc + MDU_LAT);
    endfunction

    // One pipeline cycle: drive after the edge, check mid-cycle, advance the model.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                        input bit urs, input bit urt, input bit ms, input bit hr,
                        input bit mr, input logic [4:0] wr, input bit br);
        bit e_busy, e_lu, e_stall;
        int e_sat;
        ID_Rs = rs; ID_Rt = rt; ID_use_rs = urs; ID_use_rt = urt;
        ID_mdu_start = ms; ID_hilo_read = hr;
        EX_MemRead = mr; EX_WR_out = wr; EX_branch_taken = br;
        @(negedge clk);
        e_busy  = model_busy();
        e_lu    = mr && (wr != 5'd0) && ((urs && rs == wr) || (urt && rt == wr));
        e_stall = (e_lu || (e_busy && (hr || ms))) && !br;
        e_sat   = (exp_cnt > 7) ? 7 : exp_cnt;
        chk("pc_write",    32'(PC_write),    32'(!e_stall));
        chk("if_id_write", 32'(IF_ID_write), 32'(!e_stall));
        chk("if_id_flush", 32'(IF_ID_flush), 32'(br));
        chk("id_ex_flush", 32'(ID_EX_flush), 32'(e_stall || br));
        chk("mdu_busy",    32'(mdu_busy),    32'(e_busy));
        chk("stall_cnt",   32'(stall_cnt),   32'(exp_cnt));
        chk("sat_cnt",     32'(s_stall_cnt), 32'(e_sat));
        @(posedge clk);
        if (ms && !e_stall && !br) issue_cyc = cyc;
        if (e_stall) exp_cnt++;
        cyc++;
        #1;
    endtask

    task automatic nop();
        step(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0);
    endtask

    initial begin
        int c0;
        n_total = 0; n_pass = 0;
        cyc = 0; issue_cyc = -1000; exp_cnt = 0;
        ID_Rs = '0; ID_Rt = '0; ID_use_rs = 0; ID_use_rt = 0;
        ID_mdu_start = 0; ID_hilo_read = 0; EX_MemRead = 0;
        EX_WR_out = '0; EX_branch_taken = 0;
        rst = 1'b0;
        #2;
        chk("rst_pc_write",    32'(PC_write),    32'd1);
        chk("rst_if_id_write", 32'(IF_ID_write), 32'd1);
        chk("rst_if_id_flush", 32'(IF_ID_flush), 32'd0);
        chk("rst_id_ex_flush", 32'(ID_EX_flush), 32'd0);
        chk("rst_mdu_busy",    32'(mdu_busy),    32'd0);
        chk("rst_stall_cnt",   32'(stall_cnt),   32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Load-use on rs: one bubble, then clear.
        step(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0);
        chk("lu_cnt_one", 32'(stall_cnt), 32'd1);
        step(5'd5, 5'd0, 1, 0, 0, 0, 0, 5'd0, 0);
        // Load-use through rt.
        step(5'd1, 5'd9, 1, 1, 0, 0, 1, 5'd9, 0);
        // Load into $0, and unused rt match: no stall.
        step(5'd0, 5'd0, 1, 1, 0, 0, 1, 5'd0, 0);
        step(5'd1, 5'd5, 1, 0, 0, 0, 1, 5'd5, 0);
        // mfhi with the MDU idle.
        step(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);

        // mult then mfhi: four stall cycles.
        c0 = exp_cnt;
        step(5'd2, 5'd3, 1, 1, 1, 0, 0, 5'd0, 0);
        repeat (5) step(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
        chk("mfhi_stalls", 32'(stall_cnt), 32'(c0 + 4));
        chk("mfhi_idle", 32'(mdu_busy), 32'd0);

        // Load-use with a taken branch, and a squashed mult.
        c0 = exp_cnt;
        step(5'd7, 5'd0, 1, 0, 0, 0, 1, 5'd7, 1);
        step(5'd2, 5'd3, 1, 1, 1, 0, 0, 5'd0, 1);
        chk("br_no_cnt", 32'(stall_cnt), 32'(c0));
        chk("br_no_issue", 32'(mdu_busy), 32'd0);
        // mult stalled by load-use does not start the MDU.
        step(5'd4, 5'd3, 1, 1, 1, 0, 1, 5'd4, 0);
        chk("lu_no_issue", 32'(mdu_busy), 32'd0);

        // Back-to-back mult, div.
        step(5'd2, 5'd3, 1, 1, 1, 0, 0, 5'd0, 0);
        repeat (5) step(5'd4, 5'd5, 1, 1, 1, 0, 0, 5'd0, 0);
        chk("div_reissued", 32'(mdu_busy), 32'd1);
        repeat (5) nop();

        // Reset mid-busy, asynchronously between edges.
        step(5'd2, 5'd3, 1, 1, 1, 0, 0, 5'd0, 0);
        nop();
        step(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
        ID_hilo_read = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(mdu_busy), 32'd0);
        chk("arst_cnt",  32'(stall_cnt), 32'd0);
        chk("arst_pc",   32'(PC_write),  32'd1);
        issue_cyc = -1000; exp_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);

        // Random traffic with small register indices to provoke matches.
        repeat (400) begin
            step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Stall and flush controller for the 5-stage MIPS pipeline. It sits on the ID side and complements forwarding. It detects hazards that forwarding cannot resolve: load-use, and HI/LO access while the multi-cycle mult/div unit (MDU) is busy. It then freezes PC and IF/ID and injects a bubble into ID/EX. Taken branches resolved in EX flush IF/ID and ID/EX.

Parameters:
MDU_LAT, 4, cycles the MDU stays busy after a mult/div issues (≥2)
CNT_W, 3, width of the MDU busy counter (must hold MDU_LAT)
PERF_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
ID_Rs  input  5  rs field of the instruction in ID
ID_Rt  input  5  rt field of the instruction in ID
ID_use_rs  input  1  the ID instruction reads rs
ID_use_rt  input  1  the ID instruction reads rt
ID_mdu_start  input  1  the ID instruction is mult/multu/div/divu
ID_hilo_read  input  1  the ID instruction is mfhi/mflo
EX_MemRead  input  1  the EX instruction is a load
EX_WR_out  input  5  destination register of the EX instruction
EX_branch_taken  input  1  branch or jump in EX resolved taken
PC_write  output  1  PC load enable
IF_ID_write  output  1  IF/ID register enable
IF_ID_flush  output  1  clear IF/ID to a nop
ID_EX_flush  output  1  clear ID/EX control to a nop
mdu_busy  output  1  MDU operation in flight
stall_cnt  output  PERF_W  number of stall cycles since reset

Behaviour:
- Reset (rst=0, async): state=IDLE, busy counter=0, stall_cnt=0. Outputs: PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_flush=0, mdu_busy=0. Reset during a busy period aborts it with no residual stall.
- load_use (combinational) = EX_MemRead && EX_WR_out!=0 && ((ID_use_rs && ID_Rs==EX_WR_out) || (ID_use_rt && ID_Rt==EX_WR_out)). A load into $0 never stalls.
- mdu_hz (combinational) = mdu_busy && (ID_hilo_read || ID_mdu_start).
- stall = (load_use || mdu_hz) && !EX_branch_taken.
- When stall=1 (same cycle): PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0.
- When EX_branch_taken=1: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=1. The branch takes priority over any stall, because the ID instruction is being squashed.
- Load-use costs exactly one bubble. After the bubble, EX holds a nop and the hazard clears naturally. No extra state is kept for it.
- MDU FSM, states IDLE and BUSY:
  - IDLE→BUSY on a clock edge where ID_mdu_start=1, stall=0 and EX_branch_taken=0. The counter loads MDU_LAT−1.
  - In BUSY, the counter decrements each cycle. BUSY→IDLE on the edge where the counter is 0.
  - mdu_busy=1 exactly while the state is BUSY, i.e. MDU_LAT cycles after issue.
  - A new mult/div in ID while BUSY stalls and issues on the first cycle after the FSM returns to IDLE. No back-to-back overlap.
  - An mdu_start that is squashed by a branch or stalled by load_use does not start the MDU.
  - ID_hilo_read in the IDLE state never stalls.
- stall_cnt increments on each rising edge with stall=1 and saturates at all-ones (no wrap). Flush-only cycles are not counted.
- Outputs that depend on ID/EX inputs are combinational, with zero latency. mdu_busy and stall_cnt are registered.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1
  - REG_ZERO=5'd0
  - default MDU_LAT
- One natural sub-module, mdu_busy_tracker: the FSM plus down-counter. Its ports are clk, rst, start and busy.
- Hazard decode and the perf counter stay in hazard_ctrl.

Test Plan:
1. lw $5 in EX (EX_MemRead=1, EX_WR_out=5), ID add reads rs=5, use_rs=1 → one cycle with PC_write=0, IF_ID_write=0, ID_EX_flush=1. stall_cnt goes 0→1. The next cycle (EX_MemRead=0) shows no stall.
2. lw $0 in EX, ID reads rs=0 → no stall. Same with ID_Rt=5 but use_rt=0 → no stall.
3. MDU_LAT=4: mult issues at cycle t → mdu_busy=1 for cycles t+1..t+4. mfhi presented at t+1 stalls 4 cycles and proceeds at t+5. stall_cnt=4.
4. Load-use hazard together with EX_branch_taken=1 → IF_ID_flush=1, ID_EX_flush=1, PC_write=1. stall_cnt unchanged. A squashed mult in ID leaves mdu_busy=0.
5. Back-to-back mult,div → div stalls until mdu_busy falls, then mdu_busy re-asserts for 4 more cycles.
6. Assert rst=0 mid-BUSY, asynchronously between edges → mdu_busy=0 and stall_cnt=0 immediately. A stalled mfhi proceeds once rst=1.
